dmem_arbiter: RTL and testbench

Two-port arbiter that shares the single-port data memory between the CPU data port (port 0) and a debug/loader port (port 1), which preloads and inspects memory while the CPU runs. It sits between the MIO bus RAM-side signals and `dmem`. It latches one command per access, drives the memory for exactly one cycle, returns registered read data with a done pulse, and resolves simultaneous requests round-robin. It also keeps per-port saturating access counters for display on the 7-segment mux.

---
 rtl/dmem_arbiter_if.sv | 34 +++
 rtl/dmem_arbiter.sv | 78 +++++++
 tb/tb_dmem_arbiter.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: request, completion and memory-side bus of the data memory arbiter.
// Ports: per-port request/command (req_i, we_i, ampN_i, addrN_i, wdN_i), grant and
// completion pulses (gnt_o, done_o), read data (rd_o), busy flag, memory drive
// (mem_we_o, mem_amp_o, mem_addr_o, mem_wd_o), memory read data (mem_rd_i) and
// saturating per-port access counters (cnt0_o, cnt1_o).
interface dmem_arbiter_if #(parameter int AW = 7, parameter int DW = 32);
    logic [1:0]    req_i;
    logic [1:0]    we_i;
    logic [3:0]    amp0_i, amp1_i;
    logic [AW-1:0] addr0_i, addr1_i;
    logic [DW-1:0] wd0_i, wd1_i;
    logic [1:0]    gnt_o;
    logic [1:0]    done_o;
    logic [DW-1:0] rd_o;
    logic          busy_o;
    logic          mem_we_o;
    logic [3:0]    mem_amp_o;
    logic [AW-1:0] mem_addr_o;
    logic [DW-1:0] mem_wd_o;
    logic [DW-1:0] mem_rd_i;
    logic [15:0]   cnt0_o, cnt1_o;

    modport slave (
        input  req_i, we_i, amp0_i, amp1_i, addr0_i, addr1_i, wd0_i, wd1_i, mem_rd_i,
        output gnt_o, done_o, rd_o, busy_o, mem_we_o, mem_amp_o, mem_addr_o, mem_wd_o,
               cnt0_o, cnt1_o
    );

    modport master (
        output req_i, we_i, amp0_i, amp1_i, addr0_i, addr1_i, wd0_i, wd1_i, mem_rd_i,
        input  gnt_o, done_o, rd_o, busy_o, mem_we_o, mem_amp_o, mem_addr_o, mem_wd_o,
               cnt0_o, cnt1_o
    );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin two-port arbiter in front of the single-port data memory.
// Ports: clk, rst (synchronous, active high) and bus (dmem_arbiter_if.slave) carrying
// the CPU (port 0) and debug/loader (port 1) requests, the one-cycle memory access,
// registered read data with a done pulse, and saturating per-port access counters.
module dmem_arbiter #(parameter int AW = 7, parameter int DW = 32) (
    input logic           clk,
    input logic           rst,
    dmem_arbiter_if.slave bus
);
    typedef enum logic {IDLE, ACC} state_t;
    state_t        state, state_n;
    logic          acc, latch, win, last;
    logic          cmd_we, cmd_idx;
    logic [3:0]    cmd_amp;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wd, rd;
    logic [1:0]    done;
    logic [15:0]   cnt0, cnt1;

    assign acc = (state == ACC);

    // On a tie the port that did not win last time goes next.
    always_comb begin
        state_n = IDLE;
        latch   = 1'b0;
        win     = 1'b0;
        if (state == IDLE && bus.req_i != 2'b00) begin
            latch   = 1'b1;
            win     = (bus.req_i == 2'b11) ? ~last : bus.req_i[1];
            state_n = ACC;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            last     <= 1'b1;
            done     <= 2'b00;
            rd       <= '0;
            cnt0     <= '0;
            cnt1     <= '0;
            cmd_we   <= 1'b0;
            cmd_idx  <= 1'b0;
            cmd_amp  <= '0;
            cmd_addr <= '0;
            cmd_wd   <= '0;
        end else begin
            state <= state_n;
            done  <= acc ? (cmd_idx ? 2'b10 : 2'b01) : 2'b00;
            if (acc && !cmd_we)
                rd <= bus.mem_rd_i;
            if (latch) begin
                last     <= win;
                cmd_idx  <= win;
                cmd_we   <= win ? bus.we_i[1] : bus.we_i[0];
                cmd_amp  <= win ? bus.amp1_i  : bus.amp0_i;
                cmd_addr <= win ? bus.addr1_i : bus.addr0_i;
                cmd_wd   <= win ? bus.wd1_i   : bus.wd0_i;
            end
            if (bus.gnt_o[0] && cnt0 != 16'hFFFF)
                cnt0 <= cnt0 + 16'd1;
            if (bus.gnt_o[1] && cnt1 != 16'hFFFF)
                cnt1 <= cnt1 + 16'd1;
        end
    end

    assign bus.gnt_o      = {acc & cmd_idx, acc & ~cmd_idx};
    assign bus.busy_o     = acc;
    assign bus.done_o     = done;
    assign bus.rd_o       = rd;
    // A reset landing in the access cycle must not let the write commit.
    assign bus.mem_we_o   = acc & cmd_we & ~rst;
    assign bus.mem_amp_o  = acc ? cmd_amp  : '0;
    assign bus.mem_addr_o = acc ? cmd_addr : '0;
    assign bus.mem_wd_o   = acc ? cmd_wd   : '0;
    assign bus.cnt0_o     = cnt0;
    assign bus.cnt1_o     = cnt1;
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: scoreboard bench for dmem_arbiter with a byte-enabled memory model.
module tb_dmem_arbiter;
    logic clk = 1'b0;
    logic rst;
    int   n_vec = 0;
    int   n_err = 0;

    dmem_arbiter_if #(.AW(7), .DW(32)) bus();
    dmem_arbiter #(.AW(7), .DW(32)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    logic [31:0] mem [128];
    assign bus.mem_rd_i = mem[bus.mem_addr_o];
    always @(posedge clk)
        if (bus.mem_we_o)
            for (int b = 0; b < 4; b++)
                if (bus.mem_amp_o[b]) mem[bus.mem_addr_o][8*b +: 8] <= bus.mem_wd_o[8*b +: 8];

    logic [31:0] ref_mem [128];
    logic [31:0] model_rd;
    logic [32:0] q[$];
    logic [32:0] mon_e;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    // One access: drive, wait for grant, check the memory drive, queue the expected done.
    task automatic access(input bit p, input bit w, input logic [3:0] a,
                          input logic [6:0] ad, input logic [31:0] d);
        bit          seen;
        int          waited;
        logic [31:0] e;
        @(negedge clk);
        if (p) begin
            bus.we_i[1] = w; bus.amp1_i = a; bus.addr1_i = ad; bus.wd1_i = d;
        end else begin
            bus.we_i[0] = w; bus.amp0_i = a; bus.addr0_i = ad; bus.wd0_i = d;
        end
        bus.req_i[p] = 1'b1;
        seen = 1'b0;
        waited = 0;
        for (int i = 0; i < 8 && !seen; i++) begin
            @(negedge clk);
            waited++;
            seen = bus.gnt_o[p];
        end
        bus.req_i[p] = 1'b0;
        chk("gnt_lat", waited, 1);
        if (seen) begin
            chk("mem_we", {31'd0, bus.mem_we_o}, {31'd0, w});
            chk("mem_amp", {28'd0, bus.mem_amp_o}, {28'd0, a});
            chk("mem_addr", {25'd0, bus.mem_addr_o}, {25'd0, ad});
            chk("busy", {31'd0, bus.busy_o}, 32'd1);
            if (w) begin
                chk("mem_wd", bus.mem_wd_o, d);
                for (int b = 0; b < 4; b++)
                    if (a[b]) ref_mem[ad][8*b +: 8] = d[8*b +: 8];
            end
            e = w ? model_rd : ref_mem[ad];
            model_rd = e;
            q.push_back({p, e});
        end
        @(negedge clk);
    endtask

    always @(negedge clk)
        if (bus.done_o != 2'b00) begin
            if (q.size() == 0)
                chk("done_spur", {30'd0, bus.done_o}, 32'd0);
            else begin
                mon_e = q.pop_front();
                chk("done", {30'd0, bus.done_o}, mon_e[32] ? 32'd2 : 32'd1);
                chk("rd", bus.rd_o, mon_e[31:0]);
            end
        end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [1:0] exp_g;
        rst = 1'b1;
        bus.req_i = '0; bus.we_i = '0;
        bus.amp0_i = '0; bus.amp1_i = '0;
        bus.addr0_i = '0; bus.addr1_i = '0;
        bus.wd0_i = '0; bus.wd1_i = '0;
        model_rd = '0;
        repeat (2) @(negedge clk);
        chk("rst_gnt", {30'd0, bus.gnt_o}, 32'd0);
        chk("rst_done", {30'd0, bus.done_o}, 32'd0);
        chk("rst_rd", bus.rd_o, 32'd0);
        chk("rst_busy", {31'd0, bus.busy_o}, 32'd0);
        chk("rst_cnt0", {16'd0, bus.cnt0_o}, 32'd0);
        chk("rst_cnt1", {16'd0, bus.cnt1_o}, 32'd0);
        chk("rst_mwe", {31'd0, bus.mem_we_o}, 32'd0);
        chk("rst_mamp", {28'd0, bus.mem_amp_o}, 32'd0);
        chk("rst_maddr", {25'd0, bus.mem_addr_o}, 32'd0);
        chk("rst_mwd", bus.mem_wd_o, 32'd0);
        rst = 1'b0;

        access(1'b0, 1'b1, 4'hF, 7'd5, 32'hDEADBEEF);
        access(1'b0, 1'b0, 4'hF, 7'd5, 32'd0);
        chk("cnt0_two", {16'd0, bus.cnt0_o}, 32'd2);

        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        model_rd = '0;
        bus.we_i = 2'b00; bus.addr0_i = 7'd5; bus.addr1_i = 7'd5;
        bus.req_i = 2'b11;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            exp_g = (i % 4 == 0) ? 2'b01 : (i % 4 == 2) ? 2'b10 : 2'b00;
            chk("alt_gnt", {30'd0, bus.gnt_o}, {30'd0, exp_g});
            if (exp_g != 2'b00) begin
                q.push_back({exp_g[1], ref_mem[5]});
                model_rd = ref_mem[5];
            end
            if (i == 6) bus.req_i = 2'b00;
        end

        access(1'b1, 1'b1, 4'hF, 7'd3, 32'h11223344);
        access(1'b1, 1'b1, 4'h2, 7'd3, 32'h0000AB00);
        access(1'b1, 1'b0, 4'hF, 7'd3, 32'd0);
        chk("byte_rd", bus.rd_o, 32'h1122AB44);

        access(1'b0, 1'b1, 4'hF, 7'd9, 32'h55);
        access(1'b0, 1'b0, 4'hF, 7'd9, 32'd0);
        access(1'b0, 1'b1, 4'hF, 7'd10, 32'hAAAA5555);
        chk("rd_hold", bus.rd_o, 32'h55);

        access(1'b0, 1'b1, 4'hF, 7'd7, 32'hCAFE0000);
        @(negedge clk);
        bus.we_i[0] = 1'b1; bus.amp0_i = 4'hF; bus.addr0_i = 7'd7; bus.wd0_i = 32'h1234;
        bus.req_i[0] = 1'b1;
        @(negedge clk);
        chk("racc_gnt", {30'd0, bus.gnt_o}, 32'd1);
        rst = 1'b1;
        bus.req_i = 2'b00;
        #1;
        chk("racc_we", {31'd0, bus.mem_we_o}, 32'd0);
        @(negedge clk);
        chk("racc_busy", {31'd0, bus.busy_o}, 32'd0);
        chk("racc_done", {30'd0, bus.done_o}, 32'd0);
        chk("racc_cnt0", {16'd0, bus.cnt0_o}, 32'd0);
        chk("racc_cnt1", {16'd0, bus.cnt1_o}, 32'd0);
        rst = 1'b0;
        model_rd = '0;
        access(1'b0, 1'b0, 4'hF, 7'd7, 32'd0);
        chk("racc_mem", bus.rd_o, 32'hCAFE0000);

        @(negedge clk);
        force dut.cnt1 = 16'hFFFE;
        #1;
        release dut.cnt1;
        for (int i = 0; i < 3; i++) begin
            access(1'b1, 1'b0, 4'hF, 7'd3, 32'd0);
            chk("cnt1_sat", {16'd0, bus.cnt1_o}, 32'h0000FFFF);
        end

        repeat (2) @(negedge clk);
        chk("q_empty", q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
